// File: rtl/rr_share_arb.sv
// rr_share_arb: round-robin arbiter that hands one single-owner resource to
// one of N requesters at a time.
// - Grants are registered and one-hot, and are held until the owner releases.
// - Fairness comes from a rotating priority pointer.
// - Optional feature, macro RR_SHARE_ARB_TIMEOUT_EN: adds a saturating 8-bit
//   hold counter. It forcibly reclaims the grant after MAXHOLD cycles and
//   pulses TO for one cycle when it does.
module rr_share_arb #(
  parameter int N       = 4,
  parameter int MAXHOLD = 8,
  parameter int IW      = $clog2(N)
) (
  input  logic          CLK,
  input  logic          RN,
  input  logic [N-1:0]  REQ,
  input  logic [N-1:0]  DONE,
  output logic [N-1:0]  GNT,
  output logic          GNT_VLD,
  output logic [IW-1:0] GNT_ID,
  output logic          TO
);

  localparam int           NM1    = N - 1;
  localparam logic [IW:0]  L_N    = N[IW:0];
  localparam logic [IW-1:0] L_LAST = NM1[IW-1:0];
  localparam logic [N-1:0] L_ONE  = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t        r_state;
  logic [N-1:0]  r_gnt;
  logic          r_vld;
  logic [IW-1:0] r_id;
  logic [IW-1:0] r_ptr;

  logic [N-1:0]  w_elig;
  logic [N-1:0]  w_rot;
  logic          w_found;
  logic [IW-1:0] w_off;
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_nptr;
  logic [N-1:0]  w_win_oh;
  logic          w_tmo;
  logic          w_rel;
  logic          w_take;

  // The current owner is never eligible in its own release cycle.
  // In IDLE r_gnt is zero, so every requester is eligible.
  assign w_elig = REQ & ~r_gnt;

  // Rotate the eligible set so that bit 0 corresponds to index r_ptr.
  assign w_rot = N'({w_elig, w_elig} >> r_ptr);

  // Find the first eligible requester at or above the pointer, wrapping modulo N.
  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_off   = IW'(i);
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= L_N) begin
      w_sum = w_sum - L_N;
    end
    w_win = w_sum[IW-1:0];
  end

  assign w_nptr   = (w_win == L_LAST) ? '0 : w_win + 1'b1;
  assign w_win_oh = L_ONE << w_win;

`ifdef RR_SHARE_ARB_TIMEOUT_EN
  localparam int         MAXM1   = MAXHOLD - 1;
  localparam logic [7:0] L_MAXM1 = MAXM1[7:0];

  logic [7:0] r_cnt;
  logic       r_to;

  // The counter holds (cycles already held - 1). The grant is revoked at the
  // edge where the count would reach MAXHOLD.
  assign w_tmo = (r_state == S_GRANT) && (r_cnt >= L_MAXM1);
`else
  assign w_tmo = 1'b0;
`endif

  assign w_rel  = (r_state == S_GRANT) &&
                  ((|(DONE & r_gnt)) || !(|(REQ & r_gnt)) || w_tmo);
  assign w_take = w_found && ((r_state == S_IDLE) || w_rel);

  // Grant FSM: issue a new grant, hand over, or drop to IDLE on release.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_vld   <= 1'b0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_take) begin
        r_state <= S_GRANT;
        r_gnt   <= w_win_oh;
        r_vld   <= 1'b1;
        r_id    <= w_win;
        r_ptr   <= w_nptr;
      end else if (w_rel || (r_state != S_GRANT)) begin
        r_state <= S_IDLE;
        r_gnt   <= '0;
        r_vld   <= 1'b0;
        r_id    <= '0;
      end
    end
  end

`ifdef RR_SHARE_ARB_TIMEOUT_EN
  // Hold counter (cleared on each new grant, saturating) and the one-cycle timeout pulse.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_cnt <= '0;
      r_to  <= 1'b0;
    end else begin
      r_to <= w_rel && w_tmo;
      if (w_take) begin
        r_cnt <= '0;
      end else if ((r_state == S_GRANT) && (r_cnt != 8'hFF)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign TO = r_to;
`else
  assign TO = 1'b0;
`endif

  assign GNT     = r_gnt;
  assign GNT_VLD = r_vld;
  assign GNT_ID  = r_id;

endmodule
